// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared between the fetch front end and the Controller.
//   NOP_INST      - addi x0,x0,0, driven on inst whenever fetch has nothing valid
//   opcode consts - RV32I major opcodes used by the Controller decode
//   fetch_state_e - fetch sequencer states
package riscv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with a combinational head.
//   clk, rst   - clock, asynchronous active-high reset
//   flush      - empties the FIFO at the next edge; wins over push and pop
//   push       - write push_data (ignored when full unless a pop happens too)
//   pop        - drop the head entry (ignored when empty)
//   pop_data   - current head entry, valid whenever count != 0
//   count      - number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;
  logic [DEPTH-1:0] wr_en;

  assign do_pop  = pop && (count_reg != '0);
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && !flush && (wr_ptr_reg == PTR_W'(gi));
  end

  // Storage carries no reset: only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem[i] <= push_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: core front end. Owns the PC, issues word reads to
// instruction memory, buffers returned words and hands {inst, inst_pc} to
// decode with valid/ready flow control. A redirect from decode discards the
// wrong-path stream.
//   clk, rst         - clock, asynchronous active-high reset
//   imem_req_*       - fetch request (valid/ready/addr), addr always word aligned
//   imem_rsp_*       - in-order read data from instruction memory
//   redirect(_pc)    - PC change request from decode
//   inst_valid/ready - handshake towards decode
//   inst, inst_pc    - FIFO head, NOP / 0 while nothing valid
//   misalign_err     - one-cycle pulse after a redirect to a misaligned target
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_reg;
  fetch_state_e     state_next;
  logic [31:0]      fetch_pc_reg;
  logic [CNT_W-1:0] inflight_reg;
  logic [CNT_W-1:0] inflight_next;
  logic [CNT_W-1:0] drop_reg;
  logic [CNT_W-1:0] drop_next;
  logic             block_req_reg;
  logic             misalign_err_reg;

  logic [CNT_W-1:0] data_count;
  logic [CNT_W-1:0] tag_count;
  logic [63:0]      data_head;
  logic [31:0]      tag_head;
  logic [CNT_W:0]   occupancy;
  logic             has_room;
  logic             req_accept;
  logic             rsp_keep;
  logic             inst_pop;

  // Requests in flight plus buffered words bound the FIFO, so a returning
  // word always has a slot waiting for it.
  assign occupancy = {1'b0, inflight_reg} + {1'b0, data_count};
  assign has_room  = occupancy < (CNT_W + 1)'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    imem_req_valid = 1'b0;
    unique case (state_reg)
      FETCH_BOOT: state_next = FETCH_RUN;
      // The cycle after a redirect is silent: it withdraws any old-path
      // request while the address register moves to the new target.
      FETCH_RUN:  imem_req_valid = !block_req_reg && has_room;
    endcase
  end

  assign req_accept    = imem_req_valid && imem_req_ready;
  // A response arriving with a redirect belongs to the old path.
  assign rsp_keep      = imem_rsp_valid && (drop_reg == '0) && !redirect;
  assign inflight_next = inflight_reg + CNT_W'(req_accept) - CNT_W'(imem_rsp_valid);

  always_comb begin
    drop_next = drop_reg;
    if (redirect) begin
      drop_next = inflight_next;
    end else if (imem_rsp_valid && (drop_reg != '0)) begin
      drop_next = drop_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg     <= RESET_PC;
      inflight_reg     <= '0;
      drop_reg         <= '0;
      block_req_reg    <= 1'b0;
      misalign_err_reg <= 1'b0;
    end else begin
      inflight_reg     <= inflight_next;
      drop_reg         <= drop_next;
      block_req_reg    <= redirect;
      misalign_err_reg <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
      end else if (req_accept) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
    end
  end

  // PC tags of live (not-to-be-dropped) requests, in issue order. Flushed on
  // redirect because every outstanding request then becomes part of drop.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (req_accept),
    .push_data (fetch_pc_reg),
    .pop       (rsp_keep),
    .pop_data  (tag_head),
    .count     (tag_count)
  );

  assign inst_pop = inst_valid && inst_ready;

  // Entries are {pc, inst}. A pop in the redirect cycle still completes
  // because decode samples the head before the flush lands.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_data_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (rsp_keep),
    .push_data ({tag_head, imem_rsp_data}),
    .pop       (inst_pop),
    .pop_data  (data_head),
    .count     (data_count)
  );

  assign imem_req_addr = fetch_pc_reg;
  assign inst_valid    = (data_count != '0);
  assign inst          = inst_valid ? data_head[31:0] : NOP_INST;
  assign inst_pc       = inst_valid ? data_head[63:32] : 32'h0000_0000;
  assign misalign_err  = misalign_err_reg;

  a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
    inflight_reg <= CNT_W'(DEPTH));
  a_drop_bound: assert property (@(posedge clk) disable iff (rst)
    drop_reg <= inflight_reg);
  a_fifo_bound: assert property (@(posedge clk) disable iff (rst)
    data_count <= CNT_W'(DEPTH));
  a_tag_available: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> (tag_count != '0));

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scoreboard bench for instruction_fetch.
// Stimulus pushes the hand-computed {pc, word} stream it expects into a
// queue; a separate monitor pops and compares on every decode handshake.
// The instruction memory model answers accepted requests in order, one cycle
// later, and can hold responses back or limit how many requests it accepts.
module tb_instruction_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk            = 1'b0;
  logic        rst            = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect       = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        inst_valid;
  logic        inst_ready     = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .misalign_err   (misalign_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  exp_t        mon_e;
  int          budget   = 0;
  int          accepts  = 0;
  logic        rsp_hold = 1'b0;
  int          checks   = 0;
  int          errors   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Instruction memory: everything decided on the falling edge, so the
  // handshake it records is exactly the one the DUT sees at the next rise.
  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      if (!rsp_hold && pend_q.size() != 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_q.pop_front());
      end
      imem_req_ready = (budget > 0);
      if (imem_req_valid && imem_req_ready) begin
        pend_q.push_back(imem_req_addr);
        budget  = budget - 1;
        accepts = accepts + 1;
      end
    end
  end

  // Monitor: checks every word decode takes, and NOP whenever idle.
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_valid && inst_ready) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_inst: got pc=%h inst=%h, required no word", inst_pc, inst);
        end else begin
          mon_e = exp_q.pop_front();
          if (inst_pc !== mon_e.pc || inst !== mon_e.word) begin
            errors = errors + 1;
            $display("FAIL inst_stream: got pc=%h inst=%h, required pc=%h inst=%h",
                     inst_pc, inst, mon_e.pc, mon_e.word);
          end else begin
            $display("inst pc=%h inst=%h", inst_pc, inst);
          end
        end
      end else if (!inst_valid) begin
        checks = checks + 1;
        if (inst !== NOP) begin
          errors = errors + 1;
          $display("FAIL idle_nop: got inst=%h, required %h", inst, NOP);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = base + 32'(4 * i);
      e.word = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
    chk1({name, "_idle"}, inst_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required run completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk1("rst_misalign", misalign_err, 1'b0);

    // Startup: one silent BOOT cycle, then a request for address 0.
    rst = 1'b0;
    chk1("boot_no_req", imem_req_valid, 1'b0);
    tick();
    chk1("run_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    budget = 8;
    push_seq(32'h0, 8);
    tick();
    chk1("pre_rsp_valid", inst_valid, 1'b0);
    chk("pre_rsp_nop", inst, NOP);
    tick();
    chk1("first_word_valid", inst_valid, 1'b1);
    chk("first_word_pc", inst_pc, 32'h0);
    wait_drain("stream");

    // Decode stalled: fetch stops after DEPTH requests.
    inst_ready = 1'b0;
    accepts    = 0;
    budget     = 6;
    push_seq(32'd32, 6);
    repeat (10) tick();
    chk("stall_accepts", 32'(accepts), 32'(DEPTH));
    chk1("stall_req_valid", imem_req_valid, 1'b0);
    chk("stall_head_pc", inst_pc, 32'd32);
    inst_ready = 1'b1;
    wait_drain("stall");

    // Redirect with two requests outstanding: both responses dropped.
    rsp_hold = 1'b1;
    budget   = 2;
    repeat (4) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk1("redir_req_blocked", imem_req_valid, 1'b0);
    chk("redir_addr", imem_req_addr, 32'h100);
    chk1("redir_no_misalign", misalign_err, 1'b0);
    chk1("redir_flushed", inst_valid, 1'b0);
    rsp_hold = 1'b0;
    budget   = 3;
    push_seq(32'h100, 3);
    wait_drain("redirect");

    // Redirect in the same cycle as a response and a request accept.
    rsp_hold = 1'b1;
    budget   = 2;
    repeat (4) tick();
    accepts     = 0;
    rsp_hold    = 1'b0;
    budget      = 1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("same_cycle_accept", 32'(accepts), 32'd1);
    chk("same_cycle_addr", imem_req_addr, 32'h200);
    budget = 3;
    push_seq(32'h200, 3);
    wait_drain("redirect_same_cycle");

    // Misaligned target, then back-to-back redirect to the top of memory.
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    tick();
    chk1("misalign_pulse", misalign_err, 1'b1);
    chk("misalign_addr", imem_req_addr, 32'h100);
    chk1("misalign_req_blocked", imem_req_valid, 1'b0);
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk1("misalign_once", misalign_err, 1'b0);
    chk("last_redirect_wins", imem_req_addr, 32'hFFFF_FFFC);
    budget = 2;
    push_seq(32'hFFFF_FFFC, 2);
    wait_drain("wrap");

    // Reset mid-stream: outputs return immediately, fetch restarts at 0.
    budget = 40;
    push_seq(32'h4, 40);
    repeat (8) tick();
    #2;
    rst = 1'b1;
    #1;
    chk1("mid_rst_req_valid", imem_req_valid, 1'b0);
    chk("mid_rst_req_addr", imem_req_addr, 32'h0);
    chk1("mid_rst_inst_valid", inst_valid, 1'b0);
    chk("mid_rst_inst", inst, NOP);
    chk("mid_rst_inst_pc", inst_pc, 32'h0);
    chk1("mid_rst_misalign", misalign_err, 1'b0);
    exp_q.delete();
    budget = 0;
    repeat (2) tick();
    rst    = 1'b0;
    budget = 3;
    push_seq(32'h0, 3);
    wait_drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
